led_pattern_seq: RTL and testbench



---
 rtl/led_pattern_seq_if.sv | 16 +
 rtl/led_pattern_seq.sv | 90 +++++++++
 tb/tb_led_pattern_seq.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/led_pattern_seq_if.sv
// led_pattern_seq_if: button/hold inputs and LED/mode/tick outputs of the sequencer; LED_PATTERN_BRIGHTNESS_EN adds brightness
interface led_pattern_seq_if #(parameter int NUM_LEDS = 5);
  logic btn_in;
  logic hold;
  logic [NUM_LEDS-1:0] led_out;
  logic [1:0] mode_out;
  logic tick_out;
`ifdef LED_PATTERN_BRIGHTNESS_EN
  logic [3:0] brightness;
  modport master(output btn_in, hold, brightness, input led_out, mode_out, tick_out);
  modport slave(input btn_in, hold, brightness, output led_out, mode_out, tick_out);
`else
  modport master(output btn_in, hold, input led_out, mode_out, tick_out);
  modport slave(input btn_in, hold, output led_out, mode_out, tick_out);
`endif
endinterface

// File: rtl/led_pattern_seq.sv
// led_pattern_seq: N-LED pattern sequencer with debounced mode button and hold; LED_PATTERN_BRIGHTNESS_EN adds PWM brightness
module led_pattern_seq #(
  parameter int NUM_LEDS   = 5,
  parameter int PRESCALE_W = 22,
  parameter int DEBOUNCE_W = 16
) (
  input logic clk,
  input logic reset_n,
  led_pattern_seq_if.slave bus
);
  typedef enum logic [1:0] {COUNT, CHASE, BOUNCE, BLINK} mode_t;
  mode_t mode, mode_nx;
  logic [NUM_LEDS-1:0] pat, pat_nx, led;
  logic dir, dir_nx, go_right;
  logic [1:0] btn_s, hold_s;
  logic [DEBOUNCE_W-1:0] deb_cnt;
  logic [PRESCALE_W-1:0] pre;
  logic deb_btn, differ, accept, adv, tick;
`ifdef LED_PATTERN_BRIGHTNESS_EN
  logic [3:0] pwm;
`endif
  assign differ = btn_s[1] != deb_btn;
  assign accept = differ && &deb_cnt;
  assign adv = accept && btn_s[1];
  assign go_right = dir ^ (dir ? pat[0] : pat[NUM_LEDS-1]);
  assign bus.led_out = led;
  assign bus.mode_out = mode;
  assign bus.tick_out = tick;
  // input synchronisers, debounce counter and free-running prescaler
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      btn_s <= '0;
      hold_s <= '0;
      deb_cnt <= '0;
      deb_btn <= 1'b0;
      pre <= '0;
      tick <= 1'b0;
`ifdef LED_PATTERN_BRIGHTNESS_EN
      pwm <= '0;
`endif
    end else begin
      btn_s <= {btn_s[0], bus.btn_in};
      hold_s <= {hold_s[0], bus.hold};
      deb_cnt <= differ && !accept ? deb_cnt + 1'b1 : '0;
      if (accept) deb_btn <= btn_s[1];
      pre <= pre + 1'b1;
      tick <= &pre;
`ifdef LED_PATTERN_BRIGHTNESS_EN
      pwm <= pwm + 1'b1;
`endif
    end
  // next mode and pattern: an advance reloads the pattern, hold drops ticks
  always_comb begin
    mode_nx = mode;
    pat_nx = pat;
    dir_nx = dir;
    if (adv) begin
      mode_nx = mode_t'(mode + 2'd1);
      pat_nx = (mode_nx == CHASE || mode_nx == BOUNCE) ? NUM_LEDS'(1) : '0;
      dir_nx = 1'b0;
    end else if (tick && !hold_s[1]) begin
      case (mode)
        COUNT: pat_nx = pat + 1'b1;
        CHASE: pat_nx = {pat[NUM_LEDS-2:0], pat[NUM_LEDS-1]};
        BOUNCE: begin
          pat_nx = go_right ? pat >> 1 : pat << 1;
          dir_nx = go_right;
        end
        default: pat_nx = ~pat;
      endcase
    end
  end
  // mode/pattern state and registered LED drive
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      mode <= COUNT;
      pat <= '0;
      dir <= 1'b0;
      led <= '0;
    end else begin
      mode <= mode_nx;
      pat <= pat_nx;
      dir <= dir_nx;
`ifdef LED_PATTERN_BRIGHTNESS_EN
      led <= pat & {NUM_LEDS{pwm < bus.brightness}};
`else
      led <= pat;
`endif
    end
endmodule

// File: tb/tb_led_pattern_seq.sv
// tb_led_pattern_seq: randomized self-checking bench against a step-count model of the LED sequencer
module tb_led_pattern_seq;
  localparam int N = 5, PW = 3, DW = 2, PERIOD = 1 << PW, DEB = 1 << DW;
  logic clk = 1'b0, reset_n = 1'b0;
  int n_chk = 0, n_pass = 0;
  int cyc = 0, m_mode = 0, steps = 0, run = 0;
  bit deb = 0, m_tick = 0;
  bit [1:0] bh = 0, hh = 0;
  logic [N-1:0] m_led = '0, prev;
  int c0, t_cnt, chg;

  led_pattern_seq_if #(.NUM_LEDS(N)) bus ();
  led_pattern_seq #(.NUM_LEDS(N), .PRESCALE_W(PW), .DEBOUNCE_W(DW)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  function automatic logic [N-1:0] pat_of(int mode, int s);
    int p;
    p = s % (2 * (N - 1));
    case (mode)
      0: return N'(s % (1 << N));
      1: return N'(1 << (s % N));
      2: return N'(1 << (p < N ? p : 2 * (N - 1) - p));
      default: return (s % 2) ? '1 : '0;
    endcase
  endfunction

  task automatic wait_cyc(int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic press(int hi, int lo);
    bus.btn_in = 1'b1;
    repeat (hi) @(negedge clk);
    bus.btn_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  // reference model: pattern is a function of mode and the number of accepted steps since mode entry
  initial forever begin : mdl
    bit adv;
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      cyc = 0; m_mode = 0; steps = 0; run = 0; deb = 0; m_tick = 0; bh = 0; hh = 0; m_led = '0;
    end else begin
      adv = 0;
      if (bh[1] != deb) begin
        run++;
        if (run == DEB) begin
          deb = bh[1];
          run = 0;
          adv = deb;
        end
      end else run = 0;
      m_led = pat_of(m_mode, steps)
`ifdef LED_PATTERN_BRIGHTNESS_EN
        & {N{(cyc % 16) < int'(bus.brightness)}}
`endif
        ;
      if (adv) begin
        m_mode = (m_mode + 1) % 4;
        steps = 0;
      end else if (m_tick && !hh[1]) steps++;
      cyc++;
      m_tick = (cyc % PERIOD) == 0;
      bh = {bh[0], bus.btn_in};
      hh = {hh[0], bus.hold};
    end
  end

  // every-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      chk("led", bus.led_out, m_led);
      chk("mode", bus.mode_out, m_mode);
      chk("tick", bus.tick_out, m_tick);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.btn_in = 1'b0;
    bus.hold = 1'b0;
`ifdef LED_PATTERN_BRIGHTNESS_EN
    bus.brightness = 4'd4;
`endif
    repeat (3) @(negedge clk);
    chk("rst_led", bus.led_out, 0);
    chk("rst_mode", bus.mode_out, 0);
    chk("rst_tick", bus.tick_out, 0);
    reset_n = 1'b1;
    wait_cyc(7); chk("tick_pre", bus.tick_out, 0);
    wait_cyc(8); chk("tick_first", bus.tick_out, 1);
    wait_cyc(9); chk("tick_single", bus.tick_out, 0);
`ifndef LED_PATTERN_BRIGHTNESS_EN
    wait_cyc(10); chk("led_first", bus.led_out, 1);
    wait_cyc(250); chk("led_31", bus.led_out, 31);
    wait_cyc(258); chk("led_wrap", bus.led_out, 0);
`endif
    wait_cyc(262);
    c0 = cyc;
    bus.btn_in = 1'b1;
    wait_cyc(c0 + 5); chk("mode_early", bus.mode_out, 0);
    wait_cyc(c0 + 6); chk("mode_chase", bus.mode_out, 1);
`ifndef LED_PATTERN_BRIGHTNESS_EN
    wait_cyc(c0 + 7); chk("chase_init", bus.led_out, 1);
`endif
    wait_cyc(c0 + 20);
    bus.btn_in = 1'b0;
    wait_cyc(c0 + 80);
    repeat (10) begin
      bus.btn_in = 1'b1;
      repeat (2) @(negedge clk);
      bus.btn_in = 1'b0;
      repeat (2) @(negedge clk);
    end
    repeat (8) @(negedge clk);
    chk("glitch_mode", bus.mode_out, 1);
    bus.hold = 1'b1;
    t_cnt = 0;
    chg = 0;
    prev = bus.led_out;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      t_cnt += int'(bus.tick_out);
      if (i >= 3 && bus.led_out != prev) chg++;
      prev = bus.led_out;
    end
    bus.hold = 1'b0;
    chk("hold_ticks", t_cnt, 5);
`ifndef LED_PATTERN_BRIGHTNESS_EN
    chk("hold_frozen", chg, 0);
`endif
    repeat (50) @(negedge clk);
    press(10, 10); chk("mode_bounce", bus.mode_out, 2);
    repeat (90) @(negedge clk);
    press(10, 10); chk("mode_blink", bus.mode_out, 3);
    repeat (30) @(negedge clk);
    while (cyc % PERIOD != 3) @(negedge clk);
    c0 = cyc;
    bus.btn_in = 1'b1;
    wait_cyc(c0 + 6); chk("coin_mode", bus.mode_out, 0);
`ifndef LED_PATTERN_BRIGHTNESS_EN
    wait_cyc(c0 + 7); chk("coin_init", bus.led_out, 0);
    wait_cyc(c0 + 14); chk("coin_nostep", bus.led_out, 0);
    wait_cyc(c0 + 15); chk("coin_step", bus.led_out, 1);
`endif
    wait_cyc(c0 + 16);
    bus.btn_in = 1'b0;
    repeat (12) @(negedge clk);
    press(10, 10); chk("pre_rst_mode", bus.mode_out, 1);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("async_led", bus.led_out, 0);
    chk("async_mode", bus.mode_out, 0);
    chk("async_tick", bus.tick_out, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (80) begin
      case ($urandom_range(3))
        0: press($urandom_range(6, 20), $urandom_range(6, 20));
        1: press($urandom_range(1, 3), $urandom_range(1, 6));
        2: begin
          bus.hold = 1'b1;
          repeat ($urandom_range(1, 30)) @(negedge clk);
          bus.hold = 1'b0;
        end
        default: repeat ($urandom_range(1, 30)) @(negedge clk);
      endcase
    end
    repeat (20) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
